// File: rtl/sys_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// sys_cmd_ctrl
// Command controller between the UART receiver and transmitter. It parses
// received byte frames into register-file write (0xAA), register-file
// read (0xBB), ALU-with-operands (0xCC) and ALU-only (0xDD) commands. It
// drives the register file and the ALU, then serialises the results back
// into bytes for the TX path.
//
// Ports
//   REF_CLK, RST         : clock, synchronous active-high reset
//   RX_P_DATA, RX_D_VLD  : received byte and its one-cycle valid pulse
//   RF_WR_EN, RF_RD_EN   : register-file write / read strobes
//   RF_ADDR, RF_WR_DATA  : register-file address and write data
//   RF_RD_DATA(_VLD)     : register-file read data and its valid pulse
//   ALU_EN, ALU_FUN      : ALU start strobe and function code
//   CLK_GATE_EN          : enables the gated ALU clock
//   ALU_OUT(_VLD)        : ALU result and its valid pulse
//   TX_P_DATA, TX_D_VLD  : byte to transmit and its one-cycle valid pulse
//   TX_BUSY              : transmitter busy
// All outputs are registered.
// ---------------------------------------------------------------------------
module sys_cmd_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                      REF_CLK,
    input  logic                      RST,
    input  logic [DATA_WIDTH-1:0]     RX_P_DATA,
    input  logic                      RX_D_VLD,
    output logic                      RF_WR_EN,
    output logic                      RF_RD_EN,
    output logic [ADDR_WIDTH-1:0]     RF_ADDR,
    output logic [DATA_WIDTH-1:0]     RF_WR_DATA,
    input  logic [DATA_WIDTH-1:0]     RF_RD_DATA,
    input  logic                      RF_RD_DATA_VLD,
    output logic                      ALU_EN,
    output logic [3:0]                ALU_FUN,
    output logic                      CLK_GATE_EN,
    input  logic [2*DATA_WIDTH-1:0]   ALU_OUT,
    input  logic                      ALU_OUT_VLD,
    output logic [DATA_WIDTH-1:0]     TX_P_DATA,
    output logic                      TX_D_VLD,
    input  logic                      TX_BUSY
);

    localparam logic [DATA_WIDTH-1:0] CMD_WR  = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] CMD_RD  = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] CMD_FUN = DATA_WIDTH'(8'hDD);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        WR_ADDR  = 4'd1,
        WR_DATA  = 4'd2,
        RD_ADDR  = 4'd3,
        RD_WAIT  = 4'd4,
        OPA      = 4'd5,
        OPB      = 4'd6,
        FUN      = 4'd7,
        ALU_WAIT = 4'd8,
        TX_HI    = 4'd9,
        TX_LO    = 4'd10
    } state_t;

    state_t                    state_r, state_s;
    logic                      rf_wr_en_r, rf_wr_en_s;
    logic                      rf_rd_en_r, rf_rd_en_s;
    logic [ADDR_WIDTH-1:0]     rf_addr_r, rf_addr_s;
    logic [DATA_WIDTH-1:0]     rf_wr_data_r, rf_wr_data_s;
    logic                      alu_en_r, alu_en_s;
    logic [3:0]                alu_fun_r, alu_fun_s;
    logic                      clk_gate_en_r, clk_gate_en_s;
    logic [DATA_WIDTH-1:0]     tx_p_data_r, tx_p_data_s;
    logic                      tx_d_vld_r, tx_d_vld_s;
    // Pending response: read data sits in the low byte, ALU result fills both.
    logic [2*DATA_WIDTH-1:0]   resp_r, resp_s;

    // Next-state and next-output decode; strobes default low, data holds.
    always_comb begin
        state_s      = state_r;
        rf_wr_en_s   = 1'b0;
        rf_rd_en_s   = 1'b0;
        alu_en_s     = 1'b0;
        tx_d_vld_s   = 1'b0;
        rf_addr_s    = rf_addr_r;
        rf_wr_data_s = rf_wr_data_r;
        alu_fun_s    = alu_fun_r;
        tx_p_data_s  = tx_p_data_r;
        resp_s       = resp_r;
        case (state_r)
            IDLE: begin
                if (RX_D_VLD) begin
                    case (RX_P_DATA)
                        CMD_WR:  state_s = WR_ADDR;
                        CMD_RD:  state_s = RD_ADDR;
                        CMD_ALU: state_s = OPA;
                        CMD_FUN: state_s = FUN;
                        default: state_s = IDLE;
                    endcase
                end else begin
                    state_s = IDLE;
                end
            end
            WR_ADDR: begin
                if (RX_D_VLD) begin
                    rf_addr_s = RX_P_DATA[ADDR_WIDTH-1:0];
                    state_s   = WR_DATA;
                end else begin
                    state_s = WR_ADDR;
                end
            end
            WR_DATA: begin
                if (RX_D_VLD) begin
                    rf_wr_en_s   = 1'b1;
                    rf_wr_data_s = RX_P_DATA;
                    state_s      = IDLE;
                end else begin
                    state_s = WR_DATA;
                end
            end
            RD_ADDR: begin
                if (RX_D_VLD) begin
                    rf_rd_en_s = 1'b1;
                    rf_addr_s  = RX_P_DATA[ADDR_WIDTH-1:0];
                    state_s    = RD_WAIT;
                end else begin
                    state_s = RD_ADDR;
                end
            end
            RD_WAIT: begin
                if (RF_RD_DATA_VLD) begin
                    resp_s  = {{DATA_WIDTH{1'b0}}, RF_RD_DATA};
                    state_s = TX_LO;
                end else begin
                    state_s = RD_WAIT;
                end
            end
            OPA: begin
                if (RX_D_VLD) begin
                    rf_wr_en_s   = 1'b1;
                    rf_addr_s    = {ADDR_WIDTH{1'b0}};
                    rf_wr_data_s = RX_P_DATA;
                    state_s      = OPB;
                end else begin
                    state_s = OPA;
                end
            end
            OPB: begin
                if (RX_D_VLD) begin
                    rf_wr_en_s   = 1'b1;
                    rf_addr_s    = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                    rf_wr_data_s = RX_P_DATA;
                    state_s      = FUN;
                end else begin
                    state_s = OPB;
                end
            end
            FUN: begin
                if (RX_D_VLD) begin
                    alu_en_s  = 1'b1;
                    alu_fun_s = RX_P_DATA[3:0];
                    state_s   = ALU_WAIT;
                end else begin
                    state_s = FUN;
                end
            end
            ALU_WAIT: begin
                if (ALU_OUT_VLD) begin
                    resp_s  = ALU_OUT;
                    state_s = TX_HI;
                end else begin
                    state_s = ALU_WAIT;
                end
            end
            TX_HI: begin
                if (!TX_BUSY) begin
                    tx_d_vld_s  = 1'b1;
                    tx_p_data_s = resp_r[2*DATA_WIDTH-1:DATA_WIDTH];
                    state_s     = TX_LO;
                end else begin
                    state_s = TX_HI;
                end
            end
            TX_LO: begin
                // The transmitter raises TX_BUSY one cycle after accepting a
                // byte, so a pulse last cycle means busy is not yet visible.
                if (!TX_BUSY && !tx_d_vld_r) begin
                    tx_d_vld_s  = 1'b1;
                    tx_p_data_s = resp_r[DATA_WIDTH-1:0];
                    state_s     = IDLE;
                end else begin
                    state_s = TX_LO;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        // Registered from the next state: covers FUN, ALU_WAIT and the
        // ALU_EN cycle, which always coincides with entry to ALU_WAIT.
        clk_gate_en_s = (state_s == FUN) || (state_s == ALU_WAIT);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge REF_CLK) begin
        if (RST) begin
            state_r       <= IDLE;
            rf_wr_en_r    <= 1'b0;
            rf_rd_en_r    <= 1'b0;
            rf_addr_r     <= {ADDR_WIDTH{1'b0}};
            rf_wr_data_r  <= {DATA_WIDTH{1'b0}};
            alu_en_r      <= 1'b0;
            alu_fun_r     <= 4'b0000;
            clk_gate_en_r <= 1'b0;
            tx_p_data_r   <= {DATA_WIDTH{1'b0}};
            tx_d_vld_r    <= 1'b0;
            resp_r        <= {(2*DATA_WIDTH){1'b0}};
        end else begin
            state_r       <= state_s;
            rf_wr_en_r    <= rf_wr_en_s;
            rf_rd_en_r    <= rf_rd_en_s;
            rf_addr_r     <= rf_addr_s;
            rf_wr_data_r  <= rf_wr_data_s;
            alu_en_r      <= alu_en_s;
            alu_fun_r     <= alu_fun_s;
            clk_gate_en_r <= clk_gate_en_s;
            tx_p_data_r   <= tx_p_data_s;
            tx_d_vld_r    <= tx_d_vld_s;
            resp_r        <= resp_s;
        end
    end

    assign RF_WR_EN    = rf_wr_en_r;
    assign RF_RD_EN    = rf_rd_en_r;
    assign RF_ADDR     = rf_addr_r;
    assign RF_WR_DATA  = rf_wr_data_r;
    assign ALU_EN      = alu_en_r;
    assign ALU_FUN     = alu_fun_r;
    assign CLK_GATE_EN = clk_gate_en_r;
    assign TX_P_DATA   = tx_p_data_r;
    assign TX_D_VLD    = tx_d_vld_r;

endmodule

// File: tb/tb_sys_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sys_cmd_ctrl
// Scoreboard bench for sys_cmd_ctrl. Stimulus pushes hand-computed expected
// register-file, ALU and TX events into queues; a negedge monitor pops and
// compares whenever the DUT strobes. A small environment models the
// register file, the ALU and a transmitter that stays busy after each byte.
// ---------------------------------------------------------------------------
module tb_sys_cmd_ctrl;

    logic        REF_CLK = 1'b0;
    logic        RST;
    logic [7:0]  RX_P_DATA;
    logic        RX_D_VLD;
    logic        RF_WR_EN;
    logic        RF_RD_EN;
    logic [3:0]  RF_ADDR;
    logic [7:0]  RF_WR_DATA;
    logic [7:0]  RF_RD_DATA;
    logic        RF_RD_DATA_VLD;
    logic        ALU_EN;
    logic [3:0]  ALU_FUN;
    logic        CLK_GATE_EN;
    logic [15:0] ALU_OUT;
    logic        ALU_OUT_VLD;
    logic [7:0]  TX_P_DATA;
    logic        TX_D_VLD;
    logic        TX_BUSY;

    logic        tx_model_busy;
    logic        force_busy;
    logic        busy_at_edge;
    int          tx_pulses;
    int          n_pass;
    int          n_total;

    logic [11:0] exp_wr[$];
    logic [3:0]  exp_rd[$];
    logic [3:0]  exp_alu[$];
    logic [7:0]  exp_tx[$];

    assign TX_BUSY = tx_model_busy | force_busy;

    always #5 REF_CLK = ~REF_CLK;

    sys_cmd_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .REF_CLK        (REF_CLK),
        .RST            (RST),
        .RX_P_DATA      (RX_P_DATA),
        .RX_D_VLD       (RX_D_VLD),
        .RF_WR_EN       (RF_WR_EN),
        .RF_RD_EN       (RF_RD_EN),
        .RF_ADDR        (RF_ADDR),
        .RF_WR_DATA     (RF_WR_DATA),
        .RF_RD_DATA     (RF_RD_DATA),
        .RF_RD_DATA_VLD (RF_RD_DATA_VLD),
        .ALU_EN         (ALU_EN),
        .ALU_FUN        (ALU_FUN),
        .CLK_GATE_EN    (CLK_GATE_EN),
        .ALU_OUT        (ALU_OUT),
        .ALU_OUT_VLD    (ALU_OUT_VLD),
        .TX_P_DATA      (TX_P_DATA),
        .TX_D_VLD       (TX_D_VLD),
        .TX_BUSY        (TX_BUSY)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        n_total++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic unexpected(input string name);
        n_total++;
        $display("FAIL %s: got a pulse, expected none", name);
    endtask

    // Register file, ALU and transmitter models, all updated at negedge.
    initial begin
        logic [7:0]  rf_mem [16];
        logic [7:0]  rd_q;
        logic [15:0] alu_q;
        int          rd_cnt;
        int          alu_cnt;
        int          busy_cnt;
        for (int i = 0; i < 16; i++) rf_mem[i] = 8'h00;
        rd_cnt = 0; alu_cnt = 0; busy_cnt = 0;
        rd_q = 8'h00; alu_q = 16'h0000;
        RF_RD_DATA = 8'h00; RF_RD_DATA_VLD = 1'b0;
        ALU_OUT = 16'h0000; ALU_OUT_VLD = 1'b0;
        tx_model_busy = 1'b0;
        forever begin
            @(negedge REF_CLK);
            RF_RD_DATA_VLD = 1'b0;
            ALU_OUT_VLD    = 1'b0;
            if (RF_WR_EN) rf_mem[RF_ADDR] = RF_WR_DATA;
            if (RF_RD_EN) begin
                rd_q   = rf_mem[RF_ADDR];
                rd_cnt = 2;
            end else if (rd_cnt > 0) begin
                rd_cnt--;
                if (rd_cnt == 0) begin
                    RF_RD_DATA     = rd_q;
                    RF_RD_DATA_VLD = 1'b1;
                end
            end
            if (ALU_EN) begin
                case (ALU_FUN)
                    4'd0:    alu_q = {8'h00, rf_mem[0]} + {8'h00, rf_mem[1]};
                    4'd1:    alu_q = {8'h00, rf_mem[0]} - {8'h00, rf_mem[1]};
                    4'd2:    alu_q = {8'h00, rf_mem[0]} * {8'h00, rf_mem[1]};
                    default: alu_q = 16'h0000;
                endcase
                alu_cnt = 2;
            end else if (alu_cnt > 0) begin
                alu_cnt--;
                if (alu_cnt == 0) begin
                    ALU_OUT     = alu_q;
                    ALU_OUT_VLD = 1'b1;
                end
            end
            if (TX_D_VLD) begin
                busy_cnt = 6;
            end else if (busy_cnt > 0) begin
                busy_cnt--;
            end
            tx_model_busy = (busy_cnt > 0);
        end
    end

    // TX_BUSY as seen by the DUT at each active edge.
    initial begin
        busy_at_edge = 1'b0;
        forever begin
            @(posedge REF_CLK);
            busy_at_edge = TX_BUSY;
        end
    end

    // Scoreboard monitor: pop and compare on every DUT strobe.
    initial begin
        tx_pulses = 0;
        forever begin
            @(negedge REF_CLK);
            if (!RST) begin
                if (RF_WR_EN) begin
                    if (exp_wr.size() == 0) unexpected("rf_wr");
                    else chk("rf_wr addr_data", {4'h0, RF_ADDR, RF_WR_DATA}, {4'h0, exp_wr.pop_front()});
                end
                if (RF_RD_EN) begin
                    if (exp_rd.size() == 0) unexpected("rf_rd");
                    else chk("rf_rd addr", {12'h000, RF_ADDR}, {12'h000, exp_rd.pop_front()});
                end
                if (ALU_EN) begin
                    chk("clk_gate_at_alu_en", {15'h0000, CLK_GATE_EN}, 16'h0001);
                    if (exp_alu.size() == 0) unexpected("alu_en");
                    else chk("alu_fun", {12'h000, ALU_FUN}, {12'h000, exp_alu.pop_front()});
                end
                if (TX_D_VLD) begin
                    tx_pulses++;
                    chk("tx_vld_while_busy", {15'h0000, busy_at_edge}, 16'h0000);
                    if (exp_tx.size() == 0) unexpected("tx");
                    else chk("tx_byte", {8'h00, TX_P_DATA}, {8'h00, exp_tx.pop_front()});
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge REF_CLK);
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        @(negedge REF_CLK);
        RX_D_VLD  = 1'b0;
        repeat (3) @(negedge REF_CLK);
    endtask

    function automatic int pending();
        return exp_wr.size() + exp_rd.size() + exp_alu.size() + exp_tx.size();
    endfunction

    // Wait (bounded) for all expected events, then idle to catch strays.
    task automatic drain(input string name);
        int cyc;
        cyc = 0;
        while (pending() != 0 && cyc < 2000) begin
            @(negedge REF_CLK);
            cyc++;
        end
        repeat (12) @(negedge REF_CLK);
        chk(name, 16'(pending()), 16'h0000);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, " RF_WR_EN"},    {15'h0000, RF_WR_EN},    16'h0000);
        chk({tag, " RF_RD_EN"},    {15'h0000, RF_RD_EN},    16'h0000);
        chk({tag, " ALU_EN"},      {15'h0000, ALU_EN},      16'h0000);
        chk({tag, " TX_D_VLD"},    {15'h0000, TX_D_VLD},    16'h0000);
        chk({tag, " CLK_GATE_EN"}, {15'h0000, CLK_GATE_EN}, 16'h0000);
        chk({tag, " RF_ADDR"},     {12'h000, RF_ADDR},      16'h0000);
        chk({tag, " RF_WR_DATA"},  {8'h00, RF_WR_DATA},     16'h0000);
        chk({tag, " ALU_FUN"},     {12'h000, ALU_FUN},      16'h0000);
        chk({tag, " TX_P_DATA"},   {8'h00, TX_P_DATA},      16'h0000);
    endtask

    initial begin
        int snap;
        n_pass = 0; n_total = 0;
        RST = 1'b1; RX_D_VLD = 1'b0; RX_P_DATA = 8'h00; force_busy = 1'b0;
        repeat (3) @(negedge REF_CLK);
        chk_outputs_zero("reset");
        RST = 1'b0;

        // Plain write: addr 5 <= A6, no TX activity.
        exp_wr.push_back({4'h5, 8'hA6});
        send_byte(8'hAA); send_byte(8'h05); send_byte(8'hA6);
        drain("drain write");

        // Read back addr 5.
        exp_rd.push_back(4'h5);
        exp_tx.push_back(8'hA6);
        send_byte(8'hBB); send_byte(8'h05);
        drain("drain read");

        // Operands 0x28, 0x1E, function 1 (subtract): 0x000A.
        exp_wr.push_back({4'h0, 8'h28});
        exp_wr.push_back({4'h1, 8'h1E});
        exp_alu.push_back(4'h1);
        exp_tx.push_back(8'h00);
        exp_tx.push_back(8'h0A);
        send_byte(8'hCC); send_byte(8'h28); send_byte(8'h1E); send_byte(8'h01);
        drain("drain alu sub");
        chk("clk_gate_after_alu", {15'h0000, CLK_GATE_EN}, 16'h0000);

        // Function-only, add on stored operands: 40 + 30 = 0x0046.
        exp_alu.push_back(4'h0);
        exp_tx.push_back(8'h00);
        exp_tx.push_back(8'h46);
        send_byte(8'hDD); send_byte(8'h00);
        drain("drain alu add");

        // Unknown byte dropped, then write addr 3 <= 7E.
        exp_wr.push_back({4'h3, 8'h7E});
        send_byte(8'h55); send_byte(8'hAA); send_byte(8'h03); send_byte(8'h7E);
        drain("drain ignore 55");

        // Transmitter held busy: 40 * 30 = 0x04B0 must wait, then arrive in order.
        force_busy = 1'b1;
        exp_alu.push_back(4'h2);
        exp_tx.push_back(8'h04);
        exp_tx.push_back(8'hB0);
        send_byte(8'hDD); send_byte(8'h02);
        snap = tx_pulses;
        repeat (100) @(negedge REF_CLK);
        chk("tx_held_while_busy", 16'(tx_pulses - snap), 16'h0000);
        force_busy = 1'b0;
        drain("drain busy hold");

        // Reset mid-command aborts the write; a following read works.
        send_byte(8'hAA); send_byte(8'h05);
        RST = 1'b1;
        repeat (2) @(negedge REF_CLK);
        RST = 1'b0;
        chk_outputs_zero("mid_reset");
        exp_rd.push_back(4'h5);
        exp_tx.push_back(8'hA6);
        send_byte(8'hBB); send_byte(8'h05);
        drain("drain read after reset");

        // Read back addr 3 written earlier.
        exp_rd.push_back(4'h3);
        exp_tx.push_back(8'h7E);
        send_byte(8'hBB); send_byte(8'h03);
        drain("drain read addr3");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
